// File: rtl/if_id_imm_stage_if.sv
// rtl/if_id_imm_stage_if.sv - fetch/decode handshake bundle for the IF/ID immediate stage
interface if_id_imm_stage_if #(
    parameter int XLEN = 32
);
    logic            flush_i;
    logic            inst_valid_i;
    logic [XLEN-1:0] inst_i;
    logic [XLEN-1:0] pc_i;
    logic            inst_ready_o;
    logic            id_valid_o;
    logic            id_ready_i;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] pc_o;
    logic [11:0]     imm_i_o;
    logic [11:0]     imm_s_o;
    logic            imm_sel_o;
    logic [3:0]      rs1_o;
    logic [3:0]      rs2_o;
    logic [3:0]      rd_o;
    logic            illegal_o;
`ifdef IF_ID_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt_o;
`endif

    modport slave (
        input  flush_i, inst_valid_i, inst_i, pc_i, id_ready_i,
        output inst_ready_o, id_valid_o, inst_o, pc_o, imm_i_o, imm_s_o,
               imm_sel_o, rs1_o, rs2_o, rd_o, illegal_o
`ifdef IF_ID_STALL_CNT_EN
        , output stall_cnt_o
`endif
    );

    modport master (
        output flush_i, inst_valid_i, inst_i, pc_i, id_ready_i,
        input  inst_ready_o, id_valid_o, inst_o, pc_o, imm_i_o, imm_s_o,
               imm_sel_o, rs1_o, rs2_o, rd_o, illegal_o
`ifdef IF_ID_STALL_CNT_EN
        , input stall_cnt_o
`endif
    );
endinterface

// File: rtl/if_id_imm_stage.sv
// rtl/if_id_imm_stage.sv - RV32E IF/ID skid-buffered stage with immediate/register pre-decode
// Optional stall counter enabled by macro IF_ID_STALL_CNT_EN.
module if_id_imm_stage #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    if_id_imm_stage_if.slave   bus
);
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic            main_valid, skid_valid;
    logic [XLEN-1:0] main_inst, main_pc, skid_inst, skid_pc;
    logic            accept, pop;

    // Ready depends only on the registered skid flag, cutting any path from id_ready_i.
    assign accept = bus.inst_valid_i & ~skid_valid;
    assign pop    = main_valid & bus.id_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_inst  <= '0;
            main_pc    <= '0;
            skid_inst  <= '0;
            skid_pc    <= '0;
        end else if (bus.flush_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop && skid_valid) begin
            main_inst  <= skid_inst;
            main_pc    <= skid_pc;
            skid_valid <= 1'b0;
        end else if (pop || !main_valid) begin
            main_valid <= accept;
            if (accept) begin
                main_inst <= bus.inst_i;
                main_pc   <= bus.pc_i;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_inst  <= bus.inst_i;
            skid_pc    <= bus.pc_i;
        end
    end

    assign bus.inst_ready_o = ~skid_valid;
    assign bus.id_valid_o   = main_valid;
    assign bus.inst_o       = main_inst;
    assign bus.pc_o         = main_valid ? main_pc : RST_PC;
    assign bus.imm_i_o      = main_inst[31:20];
    assign bus.imm_s_o      = {main_inst[31:25], main_inst[11:7]};
    assign bus.imm_sel_o    = (main_inst[6:0] == OP_STORE);
    assign bus.rs1_o        = main_inst[18:15];
    assign bus.rs2_o        = main_inst[23:20];
    assign bus.rd_o         = main_inst[10:7];

    // Bits 11/19/24 are the MSBs of rd/rs1/rs2; only fields the format actually uses count.
    always_comb begin
        bus.illegal_o = 1'b0;
        case (main_inst[6:0])
            OP_OP:                       bus.illegal_o = main_inst[11] | main_inst[19] | main_inst[24];
            OP_IMM, OP_LOAD, OP_JALR:    bus.illegal_o = main_inst[11] | main_inst[19];
            OP_STORE, OP_BRANCH:         bus.illegal_o = main_inst[19] | main_inst[24];
            OP_LUI, OP_AUIPC, OP_JAL:    bus.illegal_o = main_inst[11];
            default:                     bus.illegal_o = 1'b0;
        endcase
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [XLEN-1:0] stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (main_valid && !bus.id_ready_i && (stall_cnt != {XLEN{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(XLEN-1){1'b0}}, 1'b1};
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
`endif
endmodule

// File: tb/tb_if_id_imm_stage.sv
// tb/tb_if_id_imm_stage.sv - directed self-checking bench for if_id_imm_stage
module tb_if_id_imm_stage;
    localparam int          XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    if_id_imm_stage_if #(.XLEN(XLEN)) bus ();

    if_id_imm_stage #(.XLEN(XLEN), .RST_PC(RST_PC)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.inst_valid_i = v;
        bus.inst_i       = inst;
        bus.pc_i         = pc;
    endtask

    task automatic test_reset();
        bus.flush_i = 1'b0;
        bus.id_ready_i = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        step();
        step();
        total++; if (bus.id_valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.id_valid_o); else passed++;
        total++; if (bus.inst_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", bus.inst_ready_o); else passed++;
        total++; if (bus.pc_o !== RST_PC) $display("FAIL reset_pc got=%h exp=%h", bus.pc_o, RST_PC); else passed++;
        total++; if (bus.inst_o !== 32'h0 || bus.illegal_o !== 1'b0 || bus.imm_sel_o !== 1'b0)
            $display("FAIL reset_data inst=%h ill=%b sel=%b exp=0/0/0", bus.inst_o, bus.illegal_o, bus.imm_sel_o);
        else passed++;
        rst = 1'b0;
        step();
        total++; if (bus.id_valid_o !== 1'b0 || bus.pc_o !== RST_PC)
            $display("FAIL idle valid=%b pc=%h exp=0/%h", bus.id_valid_o, bus.pc_o, RST_PC);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bus.id_ready_i = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        total++; if (bus.id_valid_o !== 1'b0) $display("FAIL b2b_pre_valid got=%b exp=0", bus.id_valid_o); else passed++;
        step();
        drive(1'b1, 32'h00A12023, 32'h104);
        total++; if (bus.id_valid_o !== 1'b1 || bus.inst_o !== 32'h00500093 || bus.pc_o !== 32'h100)
            $display("FAIL b2b_first valid=%b inst=%h pc=%h exp=1/00500093/00000100", bus.id_valid_o, bus.inst_o, bus.pc_o);
        else passed++;
        total++; if (bus.imm_i_o !== 12'h005 || bus.imm_sel_o !== 1'b0 || bus.rd_o !== 4'd1)
            $display("FAIL b2b_first_dec imm_i=%h sel=%b rd=%0d exp=005/0/1", bus.imm_i_o, bus.imm_sel_o, bus.rd_o);
        else passed++;
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.id_valid_o !== 1'b1 || bus.inst_o !== 32'h00A12023 || bus.pc_o !== 32'h104)
            $display("FAIL b2b_second valid=%b inst=%h pc=%h exp=1/00a12023/00000104", bus.id_valid_o, bus.inst_o, bus.pc_o);
        else passed++;
        total++; if (bus.imm_sel_o !== 1'b1 || bus.imm_s_o !== 12'h000 || bus.rs1_o !== 4'd2 || bus.rs2_o !== 4'd10)
            $display("FAIL b2b_second_dec sel=%b imm_s=%h rs1=%0d rs2=%0d exp=1/000/2/10",
                     bus.imm_sel_o, bus.imm_s_o, bus.rs1_o, bus.rs2_o);
        else passed++;
        step();
        total++; if (bus.id_valid_o !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", bus.id_valid_o); else passed++;
    endtask

    task automatic test_skid();
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'hAAAA0013, 32'h200);
        step();
        drive(1'b1, 32'hBBBB0013, 32'h204);
        total++; if (bus.inst_ready_o !== 1'b1 || bus.inst_o !== 32'hAAAA0013)
            $display("FAIL skid_one ready=%b inst=%h exp=1/aaaa0013", bus.inst_ready_o, bus.inst_o);
        else passed++;
        step();
        drive(1'b1, 32'hCCCC0013, 32'h208);
        total++; if (bus.inst_ready_o !== 1'b0 || bus.inst_o !== 32'hAAAA0013)
            $display("FAIL skid_full ready=%b inst=%h exp=0/aaaa0013", bus.inst_ready_o, bus.inst_o);
        else passed++;
        step();
        total++; if (bus.inst_ready_o !== 1'b0 || bus.inst_o !== 32'hAAAA0013 || bus.pc_o !== 32'h200)
            $display("FAIL skid_hold ready=%b inst=%h pc=%h exp=0/aaaa0013/00000200", bus.inst_ready_o, bus.inst_o, bus.pc_o);
        else passed++;
        bus.id_ready_i = 1'b1;
        step();
        total++; if (bus.inst_o !== 32'hBBBB0013 || bus.pc_o !== 32'h204 || bus.inst_ready_o !== 1'b1)
            $display("FAIL skid_b inst=%h pc=%h ready=%b exp=bbbb0013/00000204/1", bus.inst_o, bus.pc_o, bus.inst_ready_o);
        else passed++;
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.id_valid_o !== 1'b1 || bus.inst_o !== 32'hCCCC0013 || bus.pc_o !== 32'h208)
            $display("FAIL skid_c valid=%b inst=%h pc=%h exp=1/cccc0013/00000208", bus.id_valid_o, bus.inst_o, bus.pc_o);
        else passed++;
        step();
        total++; if (bus.id_valid_o !== 1'b0) $display("FAIL skid_drain got=%b exp=0", bus.id_valid_o); else passed++;
    endtask

    task automatic test_imm();
        bus.id_ready_i = 1'b1;
        drive(1'b1, 32'hFE112E23, 32'h300);
        step();
        drive(1'b1, 32'hFFC12083, 32'h304);
        total++; if (bus.imm_s_o !== 12'hFFC || bus.imm_sel_o !== 1'b1)
            $display("FAIL imm_store imm_s=%h sel=%b exp=ffc/1", bus.imm_s_o, bus.imm_sel_o);
        else passed++;
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.imm_i_o !== 12'hFFC || bus.imm_sel_o !== 1'b0 || bus.rd_o !== 4'd1)
            $display("FAIL imm_load imm_i=%h sel=%b rd=%0d exp=ffc/0/1", bus.imm_i_o, bus.imm_sel_o, bus.rd_o);
        else passed++;
        step();
    endtask

    task automatic test_illegal();
        bus.id_ready_i = 1'b1;
        drive(1'b1, 32'h01F00033, 32'h400);
        step();
        drive(1'b1, 32'h00F00033, 32'h404);
        total++; if (bus.illegal_o !== 1'b1) $display("FAIL ill_rs2_x31 got=%b exp=1", bus.illegal_o); else passed++;
        step();
        drive(1'b1, 32'h12345837, 32'h408);
        total++; if (bus.illegal_o !== 1'b0 || bus.rs2_o !== 4'd15)
            $display("FAIL ill_rs2_x15 ill=%b rs2=%0d exp=0/15", bus.illegal_o, bus.rs2_o);
        else passed++;
        step();
        drive(1'b1, 32'h00F80013, 32'h40C);
        total++; if (bus.illegal_o !== 1'b1 || bus.rd_o !== 4'd0)
            $display("FAIL ill_lui_x16 ill=%b rd=%0d exp=1/0", bus.illegal_o, bus.rd_o);
        else passed++;
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.illegal_o !== 1'b1) $display("FAIL ill_opimm_rs1_x16 got=%b exp=1", bus.illegal_o); else passed++;
        step();
    endtask

    task automatic test_flush();
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'h11100013, 32'h500);
        step();
        drive(1'b1, 32'h22200013, 32'h504);
        step();
        drive(1'b1, 32'h33300013, 32'h508);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.id_valid_o !== 1'b0 || bus.inst_ready_o !== 1'b1)
            $display("FAIL flush_clear valid=%b ready=%b exp=0/1", bus.id_valid_o, bus.inst_ready_o);
        else passed++;
        bus.id_ready_i = 1'b1;
        step();
        total++; if (bus.id_valid_o !== 1'b0) $display("FAIL flush_no_ghost got=%b exp=0", bus.id_valid_o); else passed++;
        drive(1'b1, 32'h44400013, 32'h600);
        step();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (bus.id_valid_o !== 1'b1 || bus.inst_o !== 32'h44400013)
            $display("FAIL flush_next valid=%b inst=%h exp=1/44400013", bus.id_valid_o, bus.inst_o);
        else passed++;
        step();
    endtask

    task automatic test_mid_reset();
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'h55500013, 32'h700);
        step();
        drive(1'b1, 32'h66600013, 32'h704);
        step();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.id_valid_o !== 1'b0 || bus.inst_ready_o !== 1'b1 || bus.pc_o !== RST_PC || bus.inst_o !== 32'h0)
            $display("FAIL midreset valid=%b ready=%b pc=%h inst=%h exp=0/1/%h/0",
                     bus.id_valid_o, bus.inst_ready_o, bus.pc_o, bus.inst_o, RST_PC);
        else passed++;
        step();
        rst = 1'b0;
        bus.id_ready_i = 1'b1;
        step();
        total++; if (bus.id_valid_o !== 1'b0) $display("FAIL midreset_lost got=%b exp=0", bus.id_valid_o); else passed++;
    endtask

`ifdef IF_ID_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.id_ready_i = 1'b0;
        drive(1'b1, 32'h77700013, 32'h800);
        step();
        drive(1'b0, 32'h0, 32'h0);
        bus.flush_i = 1'b0;
        for (int i = 0; i < 5; i++) step();
        total++; if (bus.stall_cnt_o !== 32'd5) $display("FAIL stall_cnt got=%0d exp=5", bus.stall_cnt_o); else passed++;
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        total++; if (bus.stall_cnt_o !== 32'd6) $display("FAIL stall_cnt_flush got=%0d exp=6", bus.stall_cnt_o); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_skid();
        test_imm();
        test_illegal();
        test_flush();
        test_mid_reset();
`ifdef IF_ID_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
